// File: rtl/mul_div_unit_if.sv
// Operand/control and HI/LO result bundle for the iterative MIPS multiply/divide unit.
interface mul_div_unit_if #(
  parameter int unsigned WIDTH = 32
);
  logic             i_start;
  logic [1:0]       i_op;
  logic [WIDTH-1:0] i_opa;
  logic [WIDTH-1:0] i_opb;
  logic             i_hi_we;
  logic             i_lo_we;
  logic [WIDTH-1:0] i_wdata;
  logic             o_busy;
  logic             o_done;
  logic [WIDTH-1:0] o_hi;
  logic [WIDTH-1:0] o_lo;

  modport master (
    output i_start, i_op, i_opa, i_opb, i_hi_we, i_lo_we, i_wdata,
    input  o_busy, o_done, o_hi, o_lo
  );

  modport slave (
    input  i_start, i_op, i_opa, i_opb, i_hi_we, i_lo_we, i_wdata,
    output o_busy, o_done, o_hi, o_lo
  );
endinterface

// File: rtl/mul_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit owning HI/LO: one radix-2 step per cycle on
// magnitudes, sign fix-up in a final cycle. MTHI/MTLO write HI/LO directly when idle.
module mul_div_unit #(
  parameter int unsigned     WIDTH   = 32,
  parameter logic [WIDTH-1:0] DIV0_LO = {WIDTH{1'b1}}
) (
  input  logic           i_clk,
  input  logic           i_rst_n,
  mul_div_unit_if.slave  bus
);
  localparam int unsigned CW = $clog2(WIDTH);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX} state_e;

  state_e             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               is_div_q, is_div_d;
  logic               neg_q, neg_d;
  logic               rem_neg_q, rem_neg_d;
  logic               div0_q, div0_d;
  logic [WIDTH-1:0]   opa_q, opa_d;
  logic [WIDTH-1:0]   m_q, m_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               done_q, done_d;

  logic               signed_op, a_neg, b_neg;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;
  logic [WIDTH:0]     div_shift, div_diff;
  logic [2*WIDTH-1:0] div_next;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix;

  assign signed_op = ~bus.i_op[0];
  assign a_neg     = signed_op & bus.i_opa[WIDTH-1];
  assign b_neg     = signed_op & bus.i_opb[WIDTH-1];
  assign a_mag     = a_neg ? -bus.i_opa : bus.i_opa;
  assign b_mag     = b_neg ? -bus.i_opb : bus.i_opb;

  // Multiply: acc = {partial product, multiplier}; add m on LSB, shift right.
  assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, m_q} : '0);
  assign mul_next = {mul_sum, acc_q[WIDTH-1:1]};

  // Divide: acc = {remainder, dividend/quotient}; restore by keeping the unsubtracted value.
  assign div_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
  assign div_diff  = div_shift - {1'b0, m_q};
  assign div_next  = div_diff[WIDTH]
                   ? {div_shift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0}
                   : {div_diff[WIDTH-1:0],  acc_q[WIDTH-2:0], 1'b1};

  assign prod_fix = neg_q     ? -acc_q : acc_q;
  assign quo_fix  = neg_q     ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
  assign rem_fix  = rem_neg_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    is_div_d  = is_div_q;
    neg_d     = neg_q;
    rem_neg_d = rem_neg_q;
    div0_d    = div0_q;
    opa_d     = opa_q;
    m_d       = m_q;
    acc_d     = acc_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    done_d    = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (bus.i_start) begin
          state_d   = S_CALC;
          cnt_d     = '0;
          is_div_d  = bus.i_op[1];
          neg_d     = a_neg ^ b_neg;
          rem_neg_d = a_neg;
          div0_d    = (bus.i_opb == '0);
          opa_d     = bus.i_opa;
          m_d       = bus.i_op[1] ? b_mag : a_mag;
          acc_d     = {{WIDTH{1'b0}}, (bus.i_op[1] ? a_mag : b_mag)};
        end else begin
          if (bus.i_hi_we) hi_d = bus.i_wdata;
          if (bus.i_lo_we) lo_d = bus.i_wdata;
        end
      end
      S_CALC: begin
        acc_d = is_div_q ? div_next : mul_next;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(WIDTH - 1)) state_d = S_FIX;
      end
      S_FIX: begin
        state_d = S_IDLE;
        done_d  = 1'b1;
        if (!is_div_q) begin
          hi_d = prod_fix[2*WIDTH-1:WIDTH];
          lo_d = prod_fix[WIDTH-1:0];
        end else if (div0_q) begin
          hi_d = opa_q;
          lo_d = DIV0_LO;
        end else begin
          hi_d = rem_fix;
          lo_d = quo_fix;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      is_div_q  <= 1'b0;
      neg_q     <= 1'b0;
      rem_neg_q <= 1'b0;
      div0_q    <= 1'b0;
      opa_q     <= '0;
      m_q       <= '0;
      acc_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      is_div_q  <= is_div_d;
      neg_q     <= neg_d;
      rem_neg_q <= rem_neg_d;
      div0_q    <= div0_d;
      opa_q     <= opa_d;
      m_q       <= m_d;
      acc_q     <= acc_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      done_q    <= done_d;
    end
  end

  assign bus.o_busy = (state_q != S_IDLE);
  assign bus.o_done = done_q;
  assign bus.o_hi   = hi_q;
  assign bus.o_lo   = lo_q;
endmodule

// File: tb/tb_mul_div_unit.sv
// Directed bench for mul_div_unit: hand-computed HI/LO results, latency and control corner cases.
module tb_mul_div_unit;
  localparam int unsigned W = 32;
  localparam logic [1:0] OP_MULT = 2'b00, OP_MULTU = 2'b01, OP_DIV = 2'b10, OP_DIVU = 2'b11;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  mul_div_unit_if #(.WIDTH(W)) bus ();

  mul_div_unit #(.WIDTH(W), .DIV0_LO(32'hFFFF_FFFF)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  // Launch at edge E0 and wait for o_done; lat = edges after E0 (-1 on timeout),
  // busy_n = samples with o_busy high from E0 up to (not including) the done sample.
  task automatic run_op(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        output int lat, output int busy_n);
    @(negedge clk);
    bus.i_start = 1'b1; bus.i_op = op; bus.i_opa = a; bus.i_opb = b;
    @(posedge clk); #1;
    bus.i_start = 1'b0;
    lat = -1;
    busy_n = bus.o_busy ? 1 : 0;
    for (int k = 1; k <= 60; k++) begin
      @(posedge clk); #1;
      if (bus.o_done) begin lat = k; break; end
      if (bus.o_busy) busy_n++;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_checks++; if (bus.o_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", bus.o_busy); end
    n_checks++; if (bus.o_done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b expected 0", bus.o_done); end
    n_checks++; if (bus.o_hi !== 32'h0) begin n_fail++; $display("FAIL reset_hi: got %h expected 00000000", bus.o_hi); end
    n_checks++; if (bus.o_lo !== 32'h0) begin n_fail++; $display("FAIL reset_lo: got %h expected 00000000", bus.o_lo); end
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_multu;
    int lat, bn;
    run_op(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat, bn);
    n_checks++; if (lat !== 33) begin n_fail++; $display("FAIL multu_latency: got %0d expected 33", lat); end
    n_checks++; if (bn !== 33) begin n_fail++; $display("FAIL multu_busy_cycles: got %0d expected 33", bn); end
    n_checks++; if (bus.o_busy !== 1'b0) begin n_fail++; $display("FAIL multu_busy_at_done: got %b expected 0", bus.o_busy); end
    n_checks++; if (bus.o_hi !== 32'hFFFF_FFFE) begin n_fail++; $display("FAIL multu_hi: got %h expected fffffffe", bus.o_hi); end
    n_checks++; if (bus.o_lo !== 32'h0000_0001) begin n_fail++; $display("FAIL multu_lo: got %h expected 00000001", bus.o_lo); end
    @(posedge clk); #1;
    n_checks++; if (bus.o_done !== 1'b0) begin n_fail++; $display("FAIL multu_done_pulse: got %b expected 0", bus.o_done); end
  endtask

  task automatic test_mult_signed;
    int lat, bn;
    run_op(OP_MULT, 32'hFFFF_FFFD, 32'd5, lat, bn);
    n_checks++; if (lat !== 33) begin n_fail++; $display("FAIL mult_neg_latency: got %0d expected 33", lat); end
    n_checks++; if (bus.o_hi !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL mult_neg_hi: got %h expected ffffffff", bus.o_hi); end
    n_checks++; if (bus.o_lo !== 32'hFFFF_FFF1) begin n_fail++; $display("FAIL mult_neg_lo: got %h expected fffffff1", bus.o_lo); end
    run_op(OP_MULT, 32'h8000_0000, 32'h8000_0000, lat, bn);
    n_checks++; if (bus.o_hi !== 32'h4000_0000) begin n_fail++; $display("FAIL mult_minmin_hi: got %h expected 40000000", bus.o_hi); end
    n_checks++; if (bus.o_lo !== 32'h0) begin n_fail++; $display("FAIL mult_minmin_lo: got %h expected 00000000", bus.o_lo); end
  endtask

  task automatic test_div_signed;
    int lat, bn;
    run_op(OP_DIV, 32'hFFFF_FFF9, 32'd2, lat, bn);
    n_checks++; if (lat !== 33) begin n_fail++; $display("FAIL div_neg_latency: got %0d expected 33", lat); end
    n_checks++; if (bus.o_lo !== 32'hFFFF_FFFD) begin n_fail++; $display("FAIL div_neg_lo: got %h expected fffffffd", bus.o_lo); end
    n_checks++; if (bus.o_hi !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL div_neg_hi: got %h expected ffffffff", bus.o_hi); end
  endtask

  task automatic test_div_special;
    int lat, bn;
    run_op(OP_DIVU, 32'd5, 32'd0, lat, bn);
    n_checks++; if (lat !== 33) begin n_fail++; $display("FAIL divu0_latency: got %0d expected 33", lat); end
    n_checks++; if (bus.o_lo !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL divu0_lo: got %h expected ffffffff", bus.o_lo); end
    n_checks++; if (bus.o_hi !== 32'd5) begin n_fail++; $display("FAIL divu0_hi: got %h expected 00000005", bus.o_hi); end
    run_op(OP_DIV, 32'hFFFF_FFF8, 32'd0, lat, bn);
    n_checks++; if (bus.o_lo !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL div0_lo: got %h expected ffffffff", bus.o_lo); end
    n_checks++; if (bus.o_hi !== 32'hFFFF_FFF8) begin n_fail++; $display("FAIL div0_hi: got %h expected fffffff8", bus.o_hi); end
    run_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, lat, bn);
    n_checks++; if (bus.o_lo !== 32'h8000_0000) begin n_fail++; $display("FAIL div_ovf_lo: got %h expected 80000000", bus.o_lo); end
    n_checks++; if (bus.o_hi !== 32'h0) begin n_fail++; $display("FAIL div_ovf_hi: got %h expected 00000000", bus.o_hi); end
  endtask

  task automatic test_mt_and_busy;
    int lat;
    @(negedge clk); bus.i_lo_we = 1'b1; bus.i_wdata = 32'h0000_1234;
    @(posedge clk); #1; bus.i_lo_we = 1'b0;
    n_checks++; if (bus.o_lo !== 32'h0000_1234) begin n_fail++; $display("FAIL mtlo: got %h expected 00001234", bus.o_lo); end
    @(negedge clk); bus.i_hi_we = 1'b1; bus.i_wdata = 32'h0000_AAAA;
    @(posedge clk); #1; bus.i_hi_we = 1'b0;
    n_checks++; if (bus.o_hi !== 32'h0000_AAAA) begin n_fail++; $display("FAIL mthi: got %h expected 0000aaaa", bus.o_hi); end
    // MULTU 6x7; operands scrambled right after capture, second start + MTHI during busy
    @(negedge clk); bus.i_start = 1'b1; bus.i_op = OP_MULTU; bus.i_opa = 32'd6; bus.i_opb = 32'd7;
    @(posedge clk); #1;
    bus.i_start = 1'b0; bus.i_op = OP_DIV; bus.i_opa = 32'hFFFF_FFFF; bus.i_opb = 32'h0000_0003;
    @(posedge clk); #1;
    @(negedge clk);
    bus.i_start = 1'b1; bus.i_op = OP_MULT; bus.i_opa = 32'd1; bus.i_opb = 32'd1;
    bus.i_hi_we = 1'b1; bus.i_wdata = 32'h0000_5555;
    @(posedge clk); #1;
    bus.i_start = 1'b0; bus.i_hi_we = 1'b0;
    n_checks++; if (bus.o_hi !== 32'h0000_AAAA) begin n_fail++; $display("FAIL busy_hi_held: got %h expected 0000aaaa", bus.o_hi); end
    n_checks++; if (bus.o_lo !== 32'h0000_1234) begin n_fail++; $display("FAIL busy_lo_held: got %h expected 00001234", bus.o_lo); end
    lat = -1;
    for (int k = 3; k <= 60; k++) begin
      @(posedge clk); #1;
      if (bus.o_done) begin lat = k; break; end
    end
    n_checks++; if (lat !== 33) begin n_fail++; $display("FAIL ignore_start_latency: got %0d expected 33", lat); end
    n_checks++; if (bus.o_lo !== 32'd42) begin n_fail++; $display("FAIL ignore_start_lo: got %h expected 0000002a", bus.o_lo); end
    n_checks++; if (bus.o_hi !== 32'd0) begin n_fail++; $display("FAIL ignore_start_hi: got %h expected 00000000", bus.o_hi); end
    // start and write enables together while idle: start wins
    @(negedge clk);
    bus.i_start = 1'b1; bus.i_op = OP_MULT; bus.i_opa = 32'hFFFF_FFFD; bus.i_opb = 32'd5;
    bus.i_hi_we = 1'b1; bus.i_lo_we = 1'b1; bus.i_wdata = 32'hDEAD_BEEF;
    @(posedge clk); #1;
    bus.i_start = 1'b0; bus.i_hi_we = 1'b0; bus.i_lo_we = 1'b0;
    n_checks++; if (bus.o_lo !== 32'd42) begin n_fail++; $display("FAIL start_wins_lo: got %h expected 0000002a", bus.o_lo); end
    n_checks++; if (bus.o_busy !== 1'b1) begin n_fail++; $display("FAIL start_wins_busy: got %b expected 1", bus.o_busy); end
    lat = -1;
    for (int k = 1; k <= 60; k++) begin
      @(posedge clk); #1;
      if (bus.o_done) begin lat = k; break; end
    end
    n_checks++; if (lat !== 33) begin n_fail++; $display("FAIL start_wins_latency: got %0d expected 33", lat); end
    n_checks++; if (bus.o_hi !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL start_wins_hi: got %h expected ffffffff", bus.o_hi); end
    n_checks++; if (bus.o_lo !== 32'hFFFF_FFF1) begin n_fail++; $display("FAIL start_wins_res_lo: got %h expected fffffff1", bus.o_lo); end
  endtask

  task automatic test_back_to_back;
    int lat, bn;
    run_op(OP_DIVU, 32'd100, 32'd7, lat, bn);
    n_checks++; if (bus.o_lo !== 32'd14) begin n_fail++; $display("FAIL divu_lo: got %h expected 0000000e", bus.o_lo); end
    n_checks++; if (bus.o_hi !== 32'd2) begin n_fail++; $display("FAIL divu_hi: got %h expected 00000002", bus.o_hi); end
    // next start issued in the cycle o_done is high
    run_op(OP_DIV, 32'd7, 32'hFFFF_FFFE, lat, bn);
    n_checks++; if (lat !== 33) begin n_fail++; $display("FAIL b2b_latency: got %0d expected 33", lat); end
    n_checks++; if (bus.o_lo !== 32'hFFFF_FFFD) begin n_fail++; $display("FAIL b2b_lo: got %h expected fffffffd", bus.o_lo); end
    n_checks++; if (bus.o_hi !== 32'd1) begin n_fail++; $display("FAIL b2b_hi: got %h expected 00000001", bus.o_hi); end
  endtask

  task automatic test_reset_abort;
    int lat, bn;
    logic seen_done;
    @(negedge clk); bus.i_start = 1'b1; bus.i_op = OP_MULT; bus.i_opa = 32'd7; bus.i_opb = 32'd9;
    @(posedge clk); #1; bus.i_start = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk); rst_n = 1'b0;
    @(posedge clk); #1;
    n_checks++; if (bus.o_busy !== 1'b0) begin n_fail++; $display("FAIL abort_busy: got %b expected 0", bus.o_busy); end
    n_checks++; if (bus.o_hi !== 32'h0) begin n_fail++; $display("FAIL abort_hi: got %h expected 00000000", bus.o_hi); end
    n_checks++; if (bus.o_lo !== 32'h0) begin n_fail++; $display("FAIL abort_lo: got %h expected 00000000", bus.o_lo); end
    @(negedge clk); rst_n = 1'b1;
    seen_done = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      if (bus.o_done) seen_done = 1'b1;
    end
    n_checks++; if (seen_done !== 1'b0) begin n_fail++; $display("FAIL abort_no_done: got %b expected 0", seen_done); end
    run_op(OP_MULTU, 32'd3, 32'd4, lat, bn);
    n_checks++; if (lat !== 33) begin n_fail++; $display("FAIL post_abort_latency: got %0d expected 33", lat); end
    n_checks++; if (bus.o_lo !== 32'd12) begin n_fail++; $display("FAIL post_abort_lo: got %h expected 0000000c", bus.o_lo); end
    n_checks++; if (bus.o_hi !== 32'd0) begin n_fail++; $display("FAIL post_abort_hi: got %h expected 00000000", bus.o_hi); end
  endtask

  initial begin
    bus.i_start = 1'b0; bus.i_op = 2'b00; bus.i_opa = '0; bus.i_opb = '0;
    bus.i_hi_we = 1'b0; bus.i_lo_we = 1'b0; bus.i_wdata = '0;
    test_reset();
    test_multu();
    test_mult_signed();
    test_div_signed();
    test_div_special();
    test_mt_and_busy();
    test_back_to_back();
    test_reset_abort();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/mul_div_unit.md
Name: mul_div_unit

Overview:
- Iterative MIPS multiply/divide unit holding the architectural HI/LO registers.
- Sits downstream of the register file; its operands come from the registered read ports rs/rt.
- Executes MULT, MULTU, DIV and DIVU over multiple cycles and supports direct HI/LO writes (MTHI/MTLO).
- HI/LO are exposed for MFHI/MFLO, and a busy flag lets the pipeline stall.

Parameters:
- WIDTH, 32, operand width; HI and LO are each WIDTH bits.
- DIV0_LO, 32'hFFFFFFFF, LO value produced on divide-by-zero.

Ports:
- i_clk  input  1  clock; all state updates on rising edge.
- i_rst_n  input  1  synchronous reset, active low.
- i_start  input  1  launch operation; sampled only when idle.
- i_op  input  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- i_opa  input  WIDTH  rs operand (multiplicand / dividend).
- i_opb  input  WIDTH  rt operand (multiplier / divisor).
- i_hi_we  input  1  MTHI write enable.
- i_lo_we  input  1  MTLO write enable.
- i_wdata  input  WIDTH  data for MTHI/MTLO.
- o_busy  output  1  high while an operation is in progress.
- o_done  output  1  one-cycle pulse when HI/LO are updated by an operation.
- o_hi  output  WIDTH  HI register.
- o_lo  output  WIDTH  LO register.

Behaviour:
- Reset: i_rst_n low at a rising edge gives state IDLE, o_busy=0, o_done=0, o_hi=0, o_lo=0, and internal accumulators=0. Reset overrides everything, including mid-operation; an aborted operation never produces o_done.
- State IDLE:
  - At edge E0 with i_start=1, operands and op are captured into internal registers, state goes to CALC, iteration counter=0, and o_busy=1 from E0.
  - Later changes to i_opa/i_opb/i_op do not affect the result.
- State CALC: exactly WIDTH iterations, one per edge (E1..E_WIDTH).
  - Multiply uses radix-2 shift-add on 2*WIDTH-bit magnitudes.
  - Divide uses restoring shift-subtract on magnitudes.
  - For signed ops, operands are converted to magnitudes at capture and their signs are recorded.
- State FIX, one edge (E_WIDTH+1):
  - Sign correction is applied, HI/LO are written, o_done=1 for the following cycle only, o_busy=0, and state returns to IDLE.
  - Total latency from the accepting edge to HI/LO visible is WIDTH+1 cycles (33 for default).
- Result rules:
  - Multiply: {HI,LO} = full 2*WIDTH-bit product, signed or unsigned per op.
  - Divide: LO = quotient truncated toward zero; HI = remainder with the sign of the dividend.
  - Divide by zero (DIV or DIVU): LO=DIV0_LO, HI=captured dividend (i_opa unchanged).
  - Signed overflow (DIV of most-negative by -1): LO=most-negative (0x80000000), HI=0.
- i_start while o_busy=1 is ignored; there is no queueing and the current operation is not disturbed.
- MTHI/MTLO:
  - When idle, i_hi_we / i_lo_we write i_wdata into HI / LO at the next edge. Both may be asserted together, writing both.
  - While busy they are ignored.
  - If i_start and a write enable are high in the same idle cycle, i_start wins and the write is dropped.
- o_done with i_start in the same cycle: the unit is already IDLE, so the new start is accepted.
- o_hi/o_lo hold their previous values throughout CALC; intermediate values are never visible.

Test Plan:
1. MULTU 0xFFFFFFFF x 0xFFFFFFFF, start at E0 -> o_busy high E0..E32; o_done pulse after E33; HI=0xFFFFFFFE, LO=0x00000001.
2. MULT 0xFFFFFFFD (-3) x 5 -> HI=0xFFFFFFFF, LO=0xFFFFFFF1; DIVU 100/7 -> LO=14, HI=2.
3. DIV 0xFFFFFFF9 (-7) / 2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF; DIV 7 / 0xFFFFFFFE (-2) -> LO=0xFFFFFFFD, HI=1.
4. DIVU 5/0 -> LO=0xFFFFFFFF, HI=5. DIV 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0.
5. MTLO 0x1234 while idle -> o_lo=0x1234 one edge later. A second i_start plus i_hi_we during busy are both ignored, and the result matches the first operation. Operands changed at E1 do not alter the result.
6. i_rst_n low at E10 of a MULT -> next cycle o_busy=0, o_hi=o_lo=0, no o_done. A fresh MULTU 3x4 afterwards gives LO=12, HI=0 at normal latency.
